// File: rtl/picorv32_mem_rr_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port among cores.
// Optional BUSY watchdog: define PICORV32_MEM_ARB_TIMEOUT_EN.
module picorv32_mem_rr_arbiter #(
  parameter int CORES_COUNT    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [CORES_COUNT-1:0]       mem_valid_i,
  input  logic [CORES_COUNT-1:0]       mem_instr_i,
  input  logic [CORES_COUNT-1:0][31:0] mem_addr_i,
  input  logic [CORES_COUNT-1:0][31:0] mem_wdata_i,
  input  logic [CORES_COUNT-1:0][3:0]  mem_wstrb_i,
  output logic [CORES_COUNT-1:0]       mem_ready_o,
  output logic [CORES_COUNT-1:0][31:0] mem_rdata_o,
  output logic                         mem_valid_o,
  output logic                         mem_instr_o,
  output logic [31:0]                  mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic [3:0]                   mem_wstrb_o,
  input  logic                         mem_ready_i,
  input  logic [31:0]                  mem_rdata_i,
  output logic [CORES_COUNT-1:0]       grant_o,
  output logic                         timeout_o
);

  localparam int PW = $clog2(CORES_COUNT);

  if (CORES_COUNT < 2) begin : g_bad_cores
    $error("CORES_COUNT must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gnt;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_any;
  logic          w_to;
  logic          w_done;

  logic                         r_valid;
  logic                         r_instr;
  logic [31:0]                  r_addr;
  logic [31:0]                  r_wdata;
  logic [3:0]                   r_wstrb;
  logic [CORES_COUNT-1:0]       r_ready;
  logic [CORES_COUNT-1:0][31:0] r_rdata;
  logic [CORES_COUNT-1:0]       r_grant;
  logic                         r_to;

  // Scan downwards so the last hit is the one closest to r_ptr.
  always_comb begin
    int j;
    j     = 0;
    w_win = '0;
    w_any = 1'b0;
    for (int i = CORES_COUNT - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= CORES_COUNT) begin
        j = j - CORES_COUNT;
      end
      if (mem_valid_i[j]) begin
        w_win = PW'(j);
        w_any = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (r_gnt == PW'(CORES_COUNT - 1))
                   ? '0 : r_gnt + 1'b1;

`ifdef PICORV32_MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] r_cnt;

  assign w_to = (r_state == S_BUSY) && !mem_ready_i
             && (r_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_to = 1'b0;
`endif

  assign w_done = (r_state == S_BUSY) && (mem_ready_i || w_to);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (w_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // DONE ignores requests: the core still shows valid on that edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_instr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_ready <= '0;
      r_rdata <= '0;
      r_grant <= '0;
      r_to    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_valid <= 1'b1;
            r_instr <= mem_instr_i[w_win];
            r_addr  <= mem_addr_i[w_win];
            r_wdata <= mem_wdata_i[w_win];
            r_wstrb <= mem_wstrb_i[w_win];
            r_gnt   <= w_win;
            r_grant <= CORES_COUNT'(1) << w_win;
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_valid        <= 1'b0;
            r_ready[r_gnt] <= 1'b1;
            r_rdata[r_gnt] <= w_to ? 32'h0 : mem_rdata_i;
            r_ptr          <= w_ptr_nxt;
            r_to           <= w_to;
          end
        end
        S_DONE: begin
          r_ready <= '0;
          r_grant <= '0;
          r_to    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_valid_o = r_valid;
  assign mem_instr_o = r_instr;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_wstrb;
  assign mem_ready_o = r_ready;
  assign mem_rdata_o = r_rdata;
  assign grant_o     = r_grant;
  assign timeout_o   = r_to;

endmodule

// File: tb/tb_picorv32_mem_rr_arbiter.sv
// Scoreboard bench for picorv32_mem_rr_arbiter: random cores and
// downstream against a queue-based round-robin reference model.
module tb_picorv32_mem_rr_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic                clk;
  logic                resetn;
  logic [N-1:0]        mem_valid_i;
  logic [N-1:0]        mem_instr_i;
  logic [N-1:0][31:0]  mem_addr_i;
  logic [N-1:0][31:0]  mem_wdata_i;
  logic [N-1:0][3:0]   mem_wstrb_i;
  logic [N-1:0]        mem_ready_o;
  logic [N-1:0][31:0]  mem_rdata_o;
  logic                mem_valid_o;
  logic                mem_instr_o;
  logic [31:0]         mem_addr_o;
  logic [31:0]         mem_wdata_o;
  logic [3:0]          mem_wstrb_o;
  logic                mem_ready_i;
  logic [31:0]         mem_rdata_i;
  logic [N-1:0]        grant_o;
  logic                timeout_o;

  picorv32_mem_rr_arbiter #(
    .CORES_COUNT   (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_valid_i(mem_valid_i),
    .mem_instr_i(mem_instr_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o),
    .mem_rdata_o(mem_rdata_o),
    .mem_valid_o(mem_valid_o),
    .mem_instr_o(mem_instr_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .grant_o    (grant_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Original transaction of each core, as the cores intended it.
  logic        req_instr [N];
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic [3:0]  req_wstrb [N];
  int          issued = 0;

  // Downstream responder controls and scoreboard.
  bit          resp_en;
  bit          stray_en;
  int          fix_delay;
  bit          fix_data_en;
  logic [31:0] fix_data;
  logic [31:0] exp_q[$];

  // Reference model state.
  int          ptr_m;
  int          cur_gnt;
  int          cyc = 0;
  int          last_rdy = -10;
  logic [N-1:0] vprev;
  bit          vo_prev;
  bit          rib_prev;
  logic [31:0] exp_rd [N];
  logic [36:0] exp_ctl;
  logic [31:0] exp_addr;
  int          gseq[$];
  int          grants_seen = 0;

  task automatic drive_req(input int i, input logic ins,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           input logic [3:0] ws);
    req_instr[i]   = ins;
    req_addr[i]    = a;
    req_wdata[i]   = wd;
    req_wstrb[i]   = ws;
    mem_instr_i[i] = ins;
    mem_addr_i[i]  = a;
    mem_wdata_i[i] = wd;
    mem_wstrb_i[i] = ws;
    mem_valid_i[i] = 1'b1;
  endtask

  // Core: hold valid until ready is seen, garble inputs once granted.
  task automatic core_req(input int i, input logic ins,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [3:0] ws);
    bit got;
    got = 0;
    drive_req(i, ins, a, wd, ws);
    issued++;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (mem_ready_o[i]) begin
        got = 1;
      end else if (grant_o[i]) begin
        @(posedge clk);
        #1;
        mem_addr_i[i]  = $urandom;
        mem_wdata_i[i] = $urandom;
        mem_wstrb_i[i] = 4'($urandom_range(0, 15));
        mem_instr_i[i] = 1'($urandom_range(0, 1));
      end
    end
    if (!got) chk($sformatf("core%0d_wait", i), 0, 1);
    @(posedge clk);
    #1;
    mem_valid_i[i] = 1'b0;
  endtask

  task automatic core_rand(input int i, input int cnt);
    for (int t = 0; t < cnt; t++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      core_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom,
               4'($urandom_range(0, 15)));
    end
  endtask

  // Downstream memory: answers each request after a delay.
  initial begin
    int d;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en && resetn && mem_valid_o) begin
        d = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 3);
        repeat (d) begin
          @(posedge clk);
          #1;
        end
        if (mem_valid_o) begin
          mem_rdata_i = fix_data_en ? fix_data : $urandom;
          mem_ready_i = 1'b1;
          exp_q.push_back(mem_rdata_i);
          @(posedge clk);
          #1;
          mem_ready_i = 1'b0;
          mem_rdata_i = $urandom;
        end
      end else if (resp_en && stray_en
                   && $urandom_range(0, 5) == 0) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = $urandom;
        @(posedge clk);
        #1;
        mem_ready_i = 1'b0;
      end
    end
  end

  // Monitor: checks every cycle against the reference model.
  always @(negedge clk) begin
    int w;
    int j;
    logic [31:0] d;
    if (!resetn) begin
      exp_q.delete();
      ptr_m    = 0;
      cur_gnt  = 0;
      vprev    = '0;
      vo_prev  = 0;
      rib_prev = 0;
      for (int i = 0; i < N; i++) exp_rd[i] = '0;
    end else begin
      cyc++;
`ifdef PICORV32_MEM_ARB_TIMEOUT_EN
      chk("ready_timing", 64'(|mem_ready_o),
          64'(rib_prev | timeout_o));
`else
      chk("ready_timing", 64'(|mem_ready_o), 64'(rib_prev));
      chk("timeout_off", 64'(timeout_o), 0);
`endif
      if (|mem_ready_o) begin
        d = 32'h0;
        if (!timeout_o) begin
          if (exp_q.size() == 0) chk("ready_spurious", 1, 0);
          else d = exp_q.pop_front();
        end
        chk("ready_owner", 64'(mem_ready_o), 64'(oh(cur_gnt)));
        chk("done_grant", 64'(grant_o), 64'(oh(cur_gnt)));
        exp_rd[cur_gnt] = d;
        ptr_m    = (cur_gnt + 1) % N;
        last_rdy = cyc;
      end
      for (int i = 0; i < N; i++)
        chk($sformatf("rdata%0d", i), 64'(mem_rdata_o[i]),
            64'(exp_rd[i]));
      if (mem_valid_o && !vo_prev) begin
        chk("done_guard", 64'((cyc - last_rdy) >= 2), 1);
        w = -1;
        for (int k = N - 1; k >= 0; k--) begin
          j = (ptr_m + k) % N;
          if (vprev[j]) w = j;
        end
        if (w < 0) begin
          chk("grant_without_req", 1, 0);
          w = 0;
        end
        cur_gnt  = w;
        exp_addr = req_addr[w];
        exp_ctl  = {req_instr[w], req_wstrb[w], req_wdata[w]};
        gseq.push_back(w);
        grants_seen++;
      end
      if (mem_valid_o) begin
        chk("busy_grant", 64'(grant_o), 64'(oh(cur_gnt)));
        chk("down_addr", 64'(mem_addr_o), 64'(exp_addr));
        chk("down_ctl", 64'({mem_instr_o, mem_wstrb_o,
                             mem_wdata_o}), 64'(exp_ctl));
      end else if (!(|mem_ready_o)) begin
        chk("idle_grant", 64'(grant_o), 0);
      end
      vprev    = mem_valid_i;
      vo_prev  = mem_valid_o;
      rib_prev = mem_ready_i & mem_valid_o;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(mem_valid_o), 0);
    chk({tag, "_ready"}, 64'(mem_ready_o), 0);
    chk({tag, "_rdata0"}, 64'(mem_rdata_o[0]), 0);
    chk({tag, "_rdata1"}, 64'(mem_rdata_o[1]), 0);
    chk({tag, "_addr"}, 64'(mem_addr_o), 0);
    chk({tag, "_wdata"}, 64'(mem_wdata_o), 0);
    chk({tag, "_wstrb_instr"}, 64'({mem_wstrb_o, mem_instr_o}), 0);
    chk({tag, "_grant"}, 64'(grant_o), 0);
    chk({tag, "_timeout"}, 64'(timeout_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active, limit 2000000 ns");
    $fatal(1);
  end

  initial begin
    int g0;
    bit seen;
    int n;
    resetn      = 1'b0;
    mem_valid_i = '0;
    mem_instr_i = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    resp_en     = 1;
    stray_en    = 0;
    fix_delay   = -1;
    fix_data_en = 0;
    fix_data    = 32'h0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    resetn = 1'b1;

    g0 = gseq.size();
    fork
      begin
        core_req(0, 0, 32'h0000_0100, 32'h0, 4'h0);
        core_req(0, 1, 32'h0000_0104, 32'h0, 4'h0);
      end
      begin
        core_req(1, 0, 32'h0000_0200, 32'h0, 4'h0);
        core_req(1, 0, 32'h0000_0204, 32'h0, 4'h0);
      end
    join
    chk("rr_count", 64'(gseq.size() - g0), 4);
    if (gseq.size() - g0 == 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("rr_order%0d", k), 64'(gseq[g0+k]), 64'(k % 2));

    fix_delay   = 2;
    fix_data_en = 1;
    fix_data    = 32'hDEAD_BEEF;
    core_req(0, 0, 32'h0001_0040, 32'h0, 4'h0);
    chk("single_rdata", 64'(mem_rdata_o[0]), 64'h0DEAD_BEEF);
    fix_data_en = 0;

    core_req(1, 1, 32'h2000_0010, 32'h1234_5678, 4'b0011);
    chk("write_wdata", 64'(mem_wdata_o), 64'h1234_5678);
    chk("write_wstrb", 64'(mem_wstrb_o), 64'h3);
    chk("write_instr", 64'(mem_instr_o), 1);
    fix_delay = -1;

    stray_en = 1;
    fork
      core_rand(0, 25);
      core_rand(1, 25);
    join
    stray_en = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    chk("txn_count", 64'(grants_seen), 64'(issued));

    core_req(0, 0, 32'h0000_0300, 32'h0, 4'h0);
    resp_en = 0;
    drive_req(0, 1, 32'h0000_0400, 32'hA5A5_A5A5, 4'hF);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = mem_valid_o;
    end
    chk("abort_granted", 64'(seen), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    mem_valid_i[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    resetn  = 1'b1;
    resp_en = 1;
    g0 = gseq.size();
    fork
      core_req(0, 0, 32'h0000_0500, 32'h0, 4'h0);
      core_req(1, 0, 32'h0000_0600, 32'h0, 4'h0);
    join
    chk("post_reset_count", 64'(gseq.size() - g0), 2);
    if (gseq.size() - g0 == 2) begin
      chk("post_reset_first", 64'(gseq[g0]), 0);
      chk("post_reset_second", 64'(gseq[g0+1]), 1);
    end

`ifdef PICORV32_MEM_ARB_TIMEOUT_EN
    resp_en = 0;
    drive_req(0, 0, 32'h0000_0700, 32'h0, 4'h0);
    seen = 0;
    n    = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (mem_ready_o[0]) begin
        seen = 1;
        chk("to_pulse", 64'(timeout_o), 1);
        chk("to_rdata", 64'(mem_rdata_o[0]), 0);
      end else if (mem_valid_o) begin
        n++;
      end
    end
    chk("to_seen", 64'(seen), 1);
    chk("to_cycles", 64'(n), 64'(TO));
    @(posedge clk);
    #1;
    mem_valid_i[0] = 1'b0;
    mem_ready_i    = 1'b1;
    mem_rdata_i    = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    mem_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ready_ignored", 64'(mem_ready_o), 0);
    resp_en = 1;
`else
    n = 0;
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
